// File: rtl/program_loader.sv
// program_loader: parses a framed byte stream (A5, LEN_LO, LEN_HI, LEN halfwords) into instruction-cache writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the load completes.
module program_loader #(
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, FINISH} state_t;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHECK;
`else
    localparam state_t AFTER_DATA = FINISH;
`endif
    localparam logic [16:0] MAXW = 17'(MAX_WORDS);
    state_t      state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] len_q, len_d, cnt_q, cnt_d, data_q, data_d, idx_q, idx_d;
    logic [31:0] idle_q, idle_d;
    logic        err_q, err_d, done_q, done_d;
    logic        accept, timed, timeout;
    logic [15:0] len_new;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif
    assign accept  = byte_valid && byte_ready;
    assign timed   = state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK};
    assign timeout = timed && !accept && (idle_q == TIMEOUT_CYCLES - 1);
    assign len_new = {byte_in, lo_q};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lo_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        err_d   = err_q;
        done_d  = state_q == FINISH;
        idle_d  = (accept || !timed) ? '0 : idle_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (state_q == FINISH) begin
            state_d = IDLE;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    state_d = (byte_in == SYNC_BYTE) ? LEN_LO : IDLE;
                    err_d   = (byte_in == SYNC_BYTE) ? 1'b0 : err_q;
                end
                LEN_LO: begin
                    lo_d    = byte_in;
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    if (len_new == 16'd0 || {1'b0, len_new} > MAXW) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        len_d   = len_new;
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                DATA_LO: begin
                    lo_d    = byte_in;
                    state_d = DATA_HI;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_in;
`endif
                end
                DATA_HI: begin
                    data_d  = {byte_in, lo_q};
                    idx_d   = cnt_q;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = (cnt_q + 16'd1 == len_q) ? AFTER_DATA : DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_in;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    state_d = (byte_in == csum_q) ? FINISH : IDLE;
                    err_d   = err_q | (byte_in != csum_q);
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end
    // Held-CPU window is purely a function of state so reset drops it without a clock edge.
    always_comb begin
        byte_ready       = state_q != FINISH;
        busy             = state_q != IDLE;
        download_program = state_q inside {DATA_LO, DATA_HI, CHECK, FINISH};
    end
    assign instruction_index = {16'd0, idx_q};
    assign program_in        = data_q;
    assign done              = done_q;
    assign error             = err_q;
endmodule
